// File: rtl/tsi_pkg.sv
// Shared constants and sizing helper for the board input conditioner.
package tsi_pkg;

  localparam logic RX_IDLE = 1'b1;
  localparam logic TX_IDLE = 1'b1;
  localparam logic SW_RST  = 1'b0;

  // Debounce counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/tsi_debounce.sv
// Single switch channel: synchroniser chain, stable-run counter, accepted level and change strobe.
module tsi_debounce
  import tsi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic sw_o,
  output logic sw_chg_o
);

  localparam int unsigned CntW = cnt_width(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q;
  logic                   level_q;
  logic                   chg_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchronise, then accept a new level only after an unbroken run of differing samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{SW_RST}};
      cnt_q   <= '0;
      level_q <= SW_RST;
      chg_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
      chg_q  <= 1'b0;
      if (synced == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        level_q <= synced;
        cnt_q   <= '0;
        chg_q   <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign sw_o     = level_q;
  assign sw_chg_o = chg_q;

endmodule

// File: rtl/tsi_cond.sv
// Board I/O conditioner: debounced switches, synchronised/filtered rx with start-edge strobe,
// and registered tx/LED outputs. Define TSI_RX_FILTER_EN to add a 3-sample majority filter on rx.
module tsi_cond
  import tsi_pkg::*;
#(
  parameter int unsigned NUM_SW      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned LED_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_SW-1:0] sw_i,
  input  logic              rx_i,
  input  logic              tx_i,
  input  logic [LED_W-1:0]  led_i,
  output logic [NUM_SW-1:0] sw_o,
  output logic [NUM_SW-1:0] sw_chg_o,
  output logic              rx_o,
  output logic              rx_fall_o,
  output logic              tx_o,
  output logic [LED_W-1:0]  led_o
);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    tsi_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_debounce (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .sw_i    (sw_i[i]),
      .sw_o    (sw_o[i]),
      .sw_chg_o(sw_chg_o[i])
    );
  end

  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic                   rx_s;
  logic                   rx_d;
  logic                   rx_q;
  logic                   rx_prev_q;

  assign rx_s = rx_sync_q[SYNC_STAGES-1];

`ifdef TSI_RX_FILTER_EN
  logic h1_q;
  logic h2_q;

  // History of the two previous synced rx samples for the majority vote.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h1_q <= RX_IDLE;
      h2_q <= RX_IDLE;
    end else begin
      h1_q <= rx_s;
      h2_q <= h1_q;
    end
  end

  // Majority of three drops any single-cycle pulse on the synced line.
  always_comb begin
    rx_d = (rx_s & h1_q) | (rx_s & h2_q) | (h1_q & h2_q);
  end
`else
  // Unfiltered: synced sample goes straight to the output register.
  always_comb begin
    rx_d = rx_s;
  end
`endif

  // rx synchroniser, conditioned level and its one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sync_q <= {SYNC_STAGES{RX_IDLE}};
      rx_q      <= RX_IDLE;
      rx_prev_q <= RX_IDLE;
    end else begin
      rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], rx_i};
      rx_q      <= rx_d;
      rx_prev_q <= rx_q;
    end
  end

  assign rx_o      = rx_q;
  assign rx_fall_o = rx_prev_q & ~rx_q;

  // Output flops on tx and LEDs so they can be packed into I/O cells.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_o  <= TX_IDLE;
      led_o <= '0;
    end else begin
      tx_o  <= tx_i;
      led_o <= led_i;
    end
  end

endmodule

// File: tb/tb_tsi_cond.sv
// Self-checking bench for tsi_cond with NUM_SW=4, SYNC_STAGES=2, DB_CYCLES=4.
module tb_tsi_cond;

  localparam int NSW = 4;
  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int LW  = 16;
`ifdef TSI_RX_FILTER_EN
  localparam int RX_LAT = 4;
`else
  localparam int RX_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NSW-1:0] sw_i;
  logic          rx_i;
  logic          tx_i;
  logic [LW-1:0] led_i;
  logic [NSW-1:0] sw_o;
  logic [NSW-1:0] sw_chg_o;
  logic          rx_o;
  logic          rx_fall_o;
  logic          tx_o;
  logic [LW-1:0] led_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tsi_cond #(
    .NUM_SW     (NSW),
    .SYNC_STAGES(SS),
    .DB_CYCLES  (DB),
    .LED_W      (LW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .sw_i     (sw_i),
    .rx_i     (rx_i),
    .tx_i     (tx_i),
    .led_i    (led_i),
    .sw_o     (sw_o),
    .sw_chg_o (sw_chg_o),
    .rx_o     (rx_o),
    .rx_fall_o(rx_fall_o),
    .tx_o     (tx_o),
    .led_o    (led_o)
  );

  // Reference model: input sample histories plus per-channel run lengths of disagreement.
  logic [NSW-1:0] sw_hist[$];
  logic           rx_hist[$];
  int             run[NSW];
  logic [NSW-1:0] m_sw, m_chg;
  logic           m_rx, m_rx_prev, m_tx;
  logic [LW-1:0]  m_led;

  always @(posedge clk) begin
    logic [NSW-1:0] s;
    logic rs, h1, h2;
    if (rst) begin
      sw_hist = {};
      rx_hist = {};
      for (int i = 0; i < SS; i++) sw_hist.push_back('0);
      for (int i = 0; i < SS + 2; i++) rx_hist.push_back(1'b1);
      for (int i = 0; i < NSW; i++) run[i] = 0;
      m_sw = '0; m_chg = '0; m_rx = 1'b1; m_rx_prev = 1'b1; m_tx = 1'b1; m_led = '0;
    end else begin
      s = sw_hist[SS-1];
      m_chg = '0;
      for (int i = 0; i < NSW; i++) begin
        if (s[i] != m_sw[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            m_sw[i] = s[i];
            m_chg[i] = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      sw_hist.push_front(sw_i);
      void'(sw_hist.pop_back());
      rs = rx_hist[SS-1];
      h1 = rx_hist[SS];
      h2 = rx_hist[SS+1];
      m_rx_prev = m_rx;
`ifdef TSI_RX_FILTER_EN
      m_rx = (rs + h1 + h2) >= 2;
`else
      m_rx = rs;
`endif
      rx_hist.push_front(rx_i);
      void'(rx_hist.pop_back());
      m_tx = tx_i;
      m_led = led_i;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sw_i = '0; rx_i = 1'b1; tx_i = 1'b0; led_i = 16'hffff;
    do_reset(3);
    checks++;
    if (sw_o !== 4'b0 || sw_chg_o !== 4'b0) begin
      failures++;
      $display("FAIL reset_sw: sw_o=%b sw_chg_o=%b required 0000 0000", sw_o, sw_chg_o);
    end
    checks++;
    if (rx_o !== 1'b1 || rx_fall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_rx: rx_o=%b rx_fall_o=%b required 1 0", rx_o, rx_fall_o);
    end
    checks++;
    if (tx_o !== 1'b1 || led_o !== 16'h0) begin
      failures++;
      $display("FAIL reset_out: tx_o=%b led_o=%h required 1 0000", tx_o, led_o);
    end
    tx_i = 1'b1; led_i = '0;
  endtask

  task automatic test_clean_switch();
    int lat = -1;
    int nstr = 0;
    logic [NSW-1:0] first = '0;
    sw_i = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (sw_chg_o !== 4'b0) begin
        nstr++;
        if (lat < 0) begin lat = k; first = sw_chg_o; end
      end
    end
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL clean_latency: strobe at edge %0d required 6", lat);
    end
    checks++;
    if (first !== 4'b0010 || nstr !== 1) begin
      failures++;
      $display("FAIL clean_strobe: strobe=%b cycles=%0d required 0010 1", first, nstr);
    end
    checks++;
    if (sw_o !== 4'b0010) begin
      failures++;
      $display("FAIL clean_level: sw_o=%b required 0010", sw_o);
    end
  endtask

  task automatic test_bounce();
    int nstr = 0;
    int lat = -1;
    for (int p = 0; p < 4; p++) begin
      sw_i[0] = (p % 2 == 0);
      repeat (2) begin
        step();
        if (sw_chg_o !== 4'b0) nstr++;
      end
    end
    sw_i[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (sw_o[0] === 1'b1 && lat < 0) lat = k;
      if (sw_chg_o !== 4'b0 && k < 6) nstr++;
    end
    checks++;
    if (nstr !== 0) begin
      failures++;
      $display("FAIL bounce_strobe: early strobes=%0d required 0", nstr);
    end
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL bounce_latency: sw_o[0] rose at edge %0d required 6", lat);
    end
    checks++;
    if (sw_o !== 4'b0011) begin
      failures++;
      $display("FAIL bounce_level: sw_o=%b required 0011", sw_o);
    end
  endtask

  task automatic test_simultaneous();
    int lat = -1;
    int nstr = 0;
    logic [NSW-1:0] first = '0;
    sw_i = '0;
    do_reset(2);
    sw_i = 4'b1111;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (sw_chg_o !== 4'b0) begin
        nstr++;
        if (lat < 0) begin lat = k; first = sw_chg_o; end
      end
    end
    checks++;
    if (first !== 4'b1111 || nstr !== 1 || lat !== 6) begin
      failures++;
      $display("FAIL simul_strobe: strobe=%b cycles=%0d edge=%0d required 1111 1 6",
               first, nstr, lat);
    end
    // Same change, interrupted by a reset pulse mid-debounce.
    sw_i = '0;
    do_reset(2);
    sw_i = 4'b1111;
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++;
    if (sw_o !== 4'b0 || sw_chg_o !== 4'b0) begin
      failures++;
      $display("FAIL midreset_hold: sw_o=%b sw_chg_o=%b required 0000 0000", sw_o, sw_chg_o);
    end
    rst = 1'b0;
    lat = -1; nstr = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (sw_o === 4'b1111 && lat < 0) lat = k;
      if (sw_chg_o !== 4'b0) nstr++;
    end
    checks++;
    if (lat !== 6 || nstr !== 1) begin
      failures++;
      $display("FAIL midreset_rise: sw_o rose at edge %0d strobes=%0d required 6 1", lat, nstr);
    end
  endtask

  task automatic test_rx_start();
    int lat = -1;
    int nfall = 0;
    logic fall_at_lat = 1'b0;
    rx_i = 1'b1;
    repeat (6) step();
    rx_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rx_o === 1'b0 && lat < 0) begin lat = k; fall_at_lat = rx_fall_o; end
      if (rx_fall_o === 1'b1) nfall++;
    end
    checks++;
    if (lat !== RX_LAT) begin
      failures++;
      $display("FAIL rx_latency: rx_o low at edge %0d required %0d", lat, RX_LAT);
    end
    checks++;
    if (nfall !== 1 || fall_at_lat !== 1'b1) begin
      failures++;
      $display("FAIL rx_fall: pulses=%0d at_first_low=%b required 1 1", nfall, fall_at_lat);
    end
    rx_i = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_glitch();
    int nlow = 0;
    int nfall = 0;
    rx_i = 1'b0;
    step();
    if (rx_o === 1'b0) nlow++;
    rx_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rx_o === 1'b0) nlow++;
      if (rx_fall_o === 1'b1) nfall++;
    end
`ifdef TSI_RX_FILTER_EN
    checks++;
    if (nlow !== 0 || nfall !== 0) begin
      failures++;
      $display("FAIL glitch_filtered: low_cycles=%0d falls=%0d required 0 0", nlow, nfall);
    end
`else
    checks++;
    if (nlow !== 1 || nfall !== 1) begin
      failures++;
      $display("FAIL glitch_passed: low_cycles=%0d falls=%0d required 1 1", nlow, nfall);
    end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) sw_i[$urandom_range(0, NSW - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) rx_i = ~rx_i;
      tx_i = 1'($urandom);
      led_i = 16'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
      checks++;
      if (sw_o !== m_sw || sw_chg_o !== m_chg) begin
        failures++;
        $display("FAIL rand_sw c=%0d: sw_o=%b chg=%b required %b %b", c, sw_o, sw_chg_o,
                 m_sw, m_chg);
      end
      checks++;
      if (rx_o !== m_rx || rx_fall_o !== (m_rx_prev & ~m_rx)) begin
        failures++;
        $display("FAIL rand_rx c=%0d: rx_o=%b fall=%b required %b %b", c, rx_o, rx_fall_o,
                 m_rx, m_rx_prev & ~m_rx);
      end
      checks++;
      if (tx_o !== m_tx || led_o !== m_led) begin
        failures++;
        $display("FAIL rand_out c=%0d: tx_o=%b led_o=%h required %b %h", c, tx_o, led_o,
                 m_tx, m_led);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw_i = '0; rx_i = 1'b1; tx_i = 1'b1; led_i = '0;
    @(negedge clk);
    test_reset();
    test_clean_switch();
    test_bounce();
    test_simultaneous();
    test_rx_start();
    test_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
